// File: rtl/tinker_mem_pkg.sv
// Shared types, widths and the address range check for the Tinker memory responder.
package tinker_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;
    typedef enum logic {CH_FETCH, CH_DATA} mem_chan_t;

    localparam int DEFAULT_MEM_SIZE = 524288;
    localparam int ADDR_W = 32;
    localparam int INSN_W = 32;
    localparam int DATA_W = 64;

    typedef logic [ADDR_W:0] addr_ext_t;

    // One extra bit so a request that wraps past 2^32 lands out of range.
    function automatic logic addr_in_range(logic [ADDR_W-1:0] addr, mem_chan_t chan,
                                           int unsigned mem_size);
        addr_ext_t last;
        last = {1'b0, addr} + ((chan == CH_FETCH) ? addr_ext_t'(3) : addr_ext_t'(7));
        return last < addr_ext_t'(mem_size);
    endfunction

endpackage

// File: rtl/tinker_mem_if.sv
// Fetch and data request/response channels between tinker_core and the memory responder.
interface tinker_mem_if
    import tinker_mem_pkg::*;
;
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_addr;
    logic              if_resp_valid;
    logic [INSN_W-1:0] if_resp_data;
    logic              if_resp_err;

    logic              d_req_valid;
    logic              d_req_ready;
    logic              d_req_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_resp_valid;
    logic [DATA_W-1:0] d_resp_data;
    logic              d_resp_err;

    modport master (
        output if_req_valid, if_addr, d_req_valid, d_req_we, d_addr, d_wdata,
        input  if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
        input  d_req_ready, d_resp_valid, d_resp_data, d_resp_err
    );

    modport slave (
        input  if_req_valid, if_addr, d_req_valid, d_req_we, d_addr, d_wdata,
        output if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
        output d_req_ready, d_resp_valid, d_resp_data, d_resp_err
    );
endinterface

// File: rtl/tinker_byte_ram.sv
// Byte-addressed big-endian storage: one 8-byte write port, one 8-byte asynchronous read port.
module tinker_byte_ram
    import tinker_mem_pkg::*;
#(
    parameter int MEM_SIZE = DEFAULT_MEM_SIZE
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int AW = $clog2(MEM_SIZE);

    (* keep *) logic [7:0] bytes [MEM_SIZE];

    addr_ext_t w_idx [8];
    addr_ext_t r_idx [8];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_idx[i] = {1'b0, waddr} + addr_ext_t'(i);
            r_idx[i] = {1'b0, raddr} + addr_ext_t'(i);
        end
    end

    // NOTE: storage is deliberately not reset; clearing a byte array costs a loop the
    // hardware cannot do in one cycle, and software never relies on its power-up contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                if (w_idx[i] < addr_ext_t'(MEM_SIZE))
                    bytes[w_idx[i][AW-1:0]] <= wdata[63-8*i -: 8];
            end
        end
    end

    // Bytes past the end read as zero so a fetch at the top of memory stays clean.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < 8; i++) begin
            if (r_idx[i] < addr_ext_t'(MEM_SIZE))
                rdata[63-8*i -: 8] = bytes[r_idx[i][AW-1:0]];
        end
    end
endmodule

// File: rtl/tinker_mem_responder.sv
// Round-robin fetch/data arbiter with one request in flight and a fixed response latency.
module tinker_mem_responder
    import tinker_mem_pkg::*;
#(
    parameter int MEM_SIZE = DEFAULT_MEM_SIZE,
    parameter int LATENCY  = 2
) (
    input  logic        clk,
    input  logic        reset,
    tinker_mem_if.slave bus
);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    mem_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    mem_chan_t         last_grant, cur_chan, eff_chan;
    logic [ADDR_W-1:0] cur_addr, eff_addr;
    logic              cur_we, eff_we, eff_ok;
    logic              grant_fetch, accept, mem_we;
    logic [DATA_W-1:0] rdata, resp_data_q;
    logic              resp_err_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        state_nxt        = state;
        cnt_nxt          = cnt;
        bus.if_req_ready = 1'b0;
        bus.d_req_ready  = 1'b0;

        grant_fetch = bus.if_req_valid && (!bus.d_req_valid || last_grant == CH_DATA);
        if (state == IDLE && !reset) begin
            bus.if_req_ready = grant_fetch;
            bus.d_req_ready  = bus.d_req_valid && !grant_fetch;
        end
        accept = bus.if_req_ready || bus.d_req_ready;

        case (state)
            IDLE: if (accept) begin
                state_nxt = (LATENCY > 1) ? WAIT : RESP;
                cnt_nxt   = CNT_W'(LATENCY - 2);
            end
            WAIT: if (cnt == '0) state_nxt = RESP;
                  else           cnt_nxt   = cnt - 1'b1;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // In IDLE the request is still on the bus; afterwards it comes from the latches.
        if (state == IDLE) begin
            eff_chan = bus.d_req_ready ? CH_DATA : CH_FETCH;
            eff_addr = bus.d_req_ready ? bus.d_addr : bus.if_addr;
            eff_we   = bus.d_req_ready && bus.d_req_we;
        end else begin
            eff_chan = cur_chan;
            eff_addr = cur_addr;
            eff_we   = cur_we;
        end
        eff_ok = addr_in_range(eff_addr, eff_chan, MEM_SIZE);
        mem_we = bus.d_req_ready && bus.d_req_we && eff_ok;
    end

    tinker_byte_ram #(.MEM_SIZE(MEM_SIZE)) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (bus.d_addr),
        .wdata (bus.d_wdata),
        .raddr (eff_addr),
        .rdata (rdata)
    );

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= CH_DATA;
            cur_chan    <= CH_FETCH;
            cur_addr    <= '0;
            cur_we      <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                last_grant <= eff_chan;
                cur_chan   <= eff_chan;
                cur_addr   <= eff_addr;
                cur_we     <= eff_we;
            end
            // Read data is captured on the edge into RESP, after any earlier store landed.
            if (state_nxt == RESP) begin
                resp_err_q  <= !eff_ok;
                resp_data_q <= (!eff_ok || eff_we) ? '0 : rdata;
            end
        end
    end

    always_comb begin
        bus.if_resp_valid = 1'b0;
        bus.if_resp_data  = '0;
        bus.if_resp_err   = 1'b0;
        bus.d_resp_valid  = 1'b0;
        bus.d_resp_data   = '0;
        bus.d_resp_err    = 1'b0;
        if (state == RESP) begin
            if (cur_chan == CH_FETCH) begin
                bus.if_resp_valid = 1'b1;
                bus.if_resp_data  = resp_data_q[DATA_W-1 -: INSN_W];
                bus.if_resp_err   = resp_err_q;
            end else begin
                bus.d_resp_valid = 1'b1;
                bus.d_resp_data  = resp_data_q;
                bus.d_resp_err   = resp_err_q;
            end
        end
    end
endmodule
